// File: rtl/sensor_bcd_pkg.sv
// Shared types and helpers for the multi-channel sensor BCD scanner.
package sensor_bcd_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    // 10^digits; the caller subtracts one to get the largest displayable value
    function automatic logic [31:0] pow10(input int unsigned digits);
        logic [31:0] v;
        v = 32'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 32'd10;
        end
        return v;
    endfunction

    // First set bit of pend searching upward from (last+1) mod n, with wrap.
    // Returns last when nothing is pending (caller gates on |pend).
    function automatic logic [3:0] rr_pick(input logic [15:0] pend, input logic [3:0] last,
                                           input int unsigned n);
        logic [3:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= 16; i++) begin
            if (!found && (i <= n)) begin
                idx = (32'(last) + i) % n;
                if (pend[idx[3:0]]) begin
                    found = 1'b1;
                    pick  = idx[3:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Iterative shift/add-3 binary to BCD converter, one input bit per cycle, MSB first.
module bcd_dabble_core #(
    parameter int unsigned IN_W   = 12,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [IN_W-1:0]       i_raw,
    output logic                  o_done,
    output logic [DIGITS*4-1:0]   o_bcd
);

    localparam int unsigned BW   = DIGITS * 4;
    localparam int unsigned CNTW = $clog2(IN_W + 1);

    logic [IN_W-1:0] r_shift;
    logic [BW-1:0]   r_bcd;
    logic [CNTW-1:0] r_cnt;
    logic [BW-1:0]   w_adj;

    // Add 3 to every nibble that is 5 or more before the shift
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) begin
                w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then one shift step per cycle until the counter drains
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_shift <= i_raw;
            r_bcd   <= '0;
            r_cnt   <= CNTW'(IN_W);
        end else if (r_cnt != '0) begin
            r_bcd   <= {w_adj[BW-2:0], r_shift[IN_W-1]};
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    // High during the final step: o_bcd holds the finished result from the next cycle on
    assign o_done = (r_cnt == CNTW'(1));
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/sensor_bcd_scanner.sv
// Captures per-channel samples, converts them round-robin through one shared
// double-dabble engine, and keeps the per-channel BCD, overflow and alarm bank.
module sensor_bcd_scanner
    import sensor_bcd_pkg::*;
#(
    parameter int unsigned CH_N   = 5,
    parameter int unsigned IN_W   = 12,
    parameter int unsigned DIGITS = 3
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic [CH_N*IN_W-1:0]       ain_data,
    input  logic [CH_N-1:0]            ain_valid,
    input  logic [CH_N*IN_W-1:0]       thr_hi,
    input  logic [CH_N*IN_W-1:0]       thr_lo,
    output logic [CH_N*DIGITS*4-1:0]   bcd_out,
    output logic [CH_N-1:0]            bcd_upd,
    output logic [CH_N-1:0]            ovf,
    output logic [CH_N-1:0]            alarm,
    output logic [CH_N-1:0]            overrun,
    output logic                       busy
);

    localparam int unsigned BW    = DIGITS * 4;
    localparam int unsigned CW    = (CH_N > 1) ? $clog2(CH_N) : 1;
    localparam logic [31:0] LIMIT = pow10(DIGITS) - 32'd1;

    state_e                 r_state;
    logic [IN_W-1:0]        r_hold [CH_N];
    logic [CH_N-1:0]        r_pend;
    logic [3:0]             r_last;
    logic [IN_W-1:0]        r_snap;
    logic                   r_sat;
    logic [CH_N*BW-1:0]     r_bcd;
    logic [CH_N-1:0]        r_upd;
    logic [CH_N-1:0]        r_ovf;
    logic [CH_N-1:0]        r_alarm;
    logic [CH_N-1:0]        r_ovr;

    logic                   w_sel;
    logic [3:0]             w_pick;
    logic [CW-1:0]          w_sel_idx;
    logic [IN_W-1:0]        w_sel_raw;
    logic                   w_sel_sat;
    logic                   w_core_done;
    logic [BW-1:0]          w_core_bcd;

    // Round-robin choice of the next pending channel, taken only from IDLE
    always_comb begin
        w_pick    = rr_pick(16'(r_pend), r_last, CH_N);
        w_sel     = (r_state == IDLE) && (|r_pend);
        w_sel_idx = w_pick[CW-1:0];
        w_sel_raw = r_hold[w_sel_idx];
        w_sel_sat = (32'(w_sel_raw) > LIMIT);
    end

    bcd_dabble_core #(
        .IN_W   (IN_W),
        .DIGITS (DIGITS)
    ) u_core (
        .i_clk   (clk_clk),
        .i_rst   (reset_reset),
        .i_start (w_sel),
        .i_raw   (w_sel_raw),
        .o_done  (w_core_done),
        .o_bcd   (w_core_bcd)
    );

    // Scheduler FSM, output bank and capture; capture is last so it overrides pend clearing
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_last  <= 4'(CH_N - 1);
            r_snap  <= '0;
            r_sat   <= 1'b0;
            r_bcd   <= '0;
            r_upd   <= '0;
            r_ovf   <= '0;
            r_alarm <= '0;
            r_ovr   <= '0;
            for (int c = 0; c < int'(CH_N); c++) begin
                r_hold[c] <= '0;
            end
        end else begin
            r_upd <= '0;
            r_ovr <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_sel) begin
                        r_pend[w_sel_idx] <= 1'b0;
                        r_last            <= w_pick;
                        r_snap            <= w_sel_raw;
                        r_sat             <= w_sel_sat;
                        r_state           <= CONV;
                    end
                end
                CONV: begin
                    if (w_core_done) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    for (int c = 0; c < int'(CH_N); c++) begin
                        if (c == int'(r_last)) begin
                            r_bcd[c*BW +: BW] <= r_sat ? {DIGITS{4'h9}} : w_core_bcd;
                            r_ovf[c]          <= r_sat;
                            r_upd[c]          <= 1'b1;
                            // Set check first so an inverted threshold pair latches on
                            if (r_snap >= thr_hi[c*IN_W +: IN_W]) begin
                                r_alarm[c] <= 1'b1;
                            end else if (r_snap <= thr_lo[c*IN_W +: IN_W]) begin
                                r_alarm[c] <= 1'b0;
                            end
                        end
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            for (int c = 0; c < int'(CH_N); c++) begin
                if (ain_valid[c]) begin
                    r_hold[c] <= ain_data[c*IN_W +: IN_W];
                    r_pend[c] <= 1'b1;
                    // A sample being snapshotted this cycle is not lost
                    if (r_pend[c] && !(w_sel && (int'(w_pick) == c))) begin
                        r_ovr[c] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bcd_out = r_bcd;
    assign bcd_upd = r_upd;
    assign ovf     = r_ovf;
    assign alarm   = r_alarm;
    assign overrun = r_ovr;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_sensor_bcd_scanner.sv
// Directed bench for sensor_bcd_scanner (5 channels, 12-bit samples, 3 digits).
module tb_sensor_bcd_scanner;

    localparam int CH_N   = 5;
    localparam int IN_W   = 12;
    localparam int DIGITS = 3;

    logic                      clk_clk = 1'b0;
    logic                      reset_reset;
    logic [CH_N*IN_W-1:0]      ain_data;
    logic [CH_N-1:0]           ain_valid;
    logic [CH_N*IN_W-1:0]      thr_hi;
    logic [CH_N*IN_W-1:0]      thr_lo;
    logic [CH_N*DIGITS*4-1:0]  bcd_out;
    logic [CH_N-1:0]           bcd_upd;
    logic [CH_N-1:0]           ovf;
    logic [CH_N-1:0]           alarm;
    logic [CH_N-1:0]           overrun;
    logic                      busy;

    int n_pass  = 0;
    int n_total = 0;
    int n;

    sensor_bcd_scanner #(
        .CH_N   (CH_N),
        .IN_W   (IN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .ain_data    (ain_data),
        .ain_valid   (ain_valid),
        .thr_hi      (thr_hi),
        .thr_lo      (thr_lo),
        .bcd_out     (bcd_out),
        .bcd_upd     (bcd_upd),
        .ovf         (ovf),
        .alarm       (alarm),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [11:0] v);
        ain_data[ch*IN_W +: IN_W] = v;
        ain_valid[ch] = 1'b1;
    endtask

    task automatic fire();
        tick();
        ain_valid = '0;
    endtask

    task automatic wait_upd(input int ch, input int budget, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bcd_upd[ch] && cnt < budget);
    endtask

    function automatic logic [11:0] bcd_of(input int ch);
        return bcd_out[ch*12 +: 12];
    endfunction

    initial begin
        reset_reset = 1'b1;
        ain_data    = '0;
        ain_valid   = '0;
        for (int c = 0; c < CH_N; c++) begin
            thr_hi[c*IN_W +: IN_W] = 12'd4095;
            thr_lo[c*IN_W +: IN_W] = 12'd0;
        end
        #23;
        chk("rst_bcd", 64'(bcd_out), 64'd0);
        chk("rst_flags", {ovf, alarm, overrun, bcd_upd}, 20'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_reset = 1'b0;
        tick();

        // Single sample, exact latency, neighbours untouched
        load(2, 12'd857);
        fire();
        wait_upd(2, 40, n);
        chk("single_lat", n, 14);
        chk("single_bus", 64'(bcd_out), 64'(60'h857 << 24));
        chk("single_upd", 64'(bcd_upd), 64'b00100);
        chk("single_ovf", 64'(ovf), 64'd0);
        tick();
        chk("single_upd_pulse", 64'(bcd_upd), 64'd0);
        chk("single_idle", 64'(busy), 64'd0);

        // Saturation and the exact boundary
        load(0, 12'd4095);
        fire();
        wait_upd(0, 40, n);
        chk("sat_bcd", bcd_of(0), 12'h999);
        chk("sat_ovf", ovf[0], 1'b1);
        load(0, 12'd999);
        fire();
        wait_upd(0, 40, n);
        chk("edge_bcd", bcd_of(0), 12'h999);
        chk("edge_ovf", ovf[0], 1'b0);

        // Put last at channel 4 before the round-robin check
        load(4, 12'd42);
        fire();
        wait_upd(4, 40, n);
        chk("ch4_bcd", bcd_of(4), 12'h042);

        load(0, 12'd12);
        load(3, 12'd345);
        load(4, 12'd678);
        fire();
        wait_upd(0, 40, n);
        chk("rr0_lat", n, 14);
        chk("rr0_bcd", bcd_of(0), 12'h012);
        wait_upd(3, 40, n);
        chk("rr3_gap", n, 14);
        chk("rr3_bcd", bcd_of(3), 12'h345);
        wait_upd(4, 40, n);
        chk("rr4_gap", n, 14);
        chk("rr4_bcd", bcd_of(4), 12'h678);
        chk("rr4_keep0", bcd_of(0), 12'h012);

        load(0, 12'd5);
        load(4, 12'd9);
        fire();
        wait_upd(0, 40, n);
        chk("wrap0_lat", n, 14);
        chk("wrap0_bcd", bcd_of(0), 12'h005);
        wait_upd(4, 40, n);
        chk("wrap4_gap", n, 14);
        chk("wrap4_bcd", bcd_of(4), 12'h009);

        // Overrun while the engine is busy on another channel
        load(2, 12'd1);
        fire();
        load(1, 12'd100);
        fire();
        chk("ovr_none_first", 64'(overrun), 64'd0);
        load(1, 12'd200);
        fire();
        chk("ovr_pulse", 64'(overrun), 64'b00010);
        tick();
        chk("ovr_one_cycle", 64'(overrun), 64'd0);
        wait_upd(2, 40, n);
        chk("ovr_ch2_bcd", bcd_of(2), 12'h001);
        wait_upd(1, 40, n);
        chk("ovr_ch1_gap", n, 14);
        chk("ovr_ch1_bcd", bcd_of(1), 12'h200);

        // New sample on the channel under conversion
        load(1, 12'd300);
        fire();
        repeat (4) tick();
        load(1, 12'd301);
        fire();
        chk("midconv_no_ovr", 64'(overrun), 64'd0);
        wait_upd(1, 40, n);
        chk("midconv_first_lat", n, 9);
        chk("midconv_first", bcd_of(1), 12'h300);
        wait_upd(1, 40, n);
        chk("midconv_second_gap", n, 14);
        chk("midconv_second", bcd_of(1), 12'h301);

        // Hysteresis on channel 3
        thr_hi[3*IN_W +: IN_W] = 12'd300;
        thr_lo[3*IN_W +: IN_W] = 12'd200;
        load(3, 12'd250); fire(); wait_upd(3, 40, n); chk("alm_250a", alarm[3], 1'b0);
        load(3, 12'd310); fire(); wait_upd(3, 40, n); chk("alm_310", alarm[3], 1'b1);
        load(3, 12'd250); fire(); wait_upd(3, 40, n); chk("alm_250b", alarm[3], 1'b1);
        load(3, 12'd200); fire(); wait_upd(3, 40, n); chk("alm_200", alarm[3], 1'b0);
        load(3, 12'd250); fire(); wait_upd(3, 40, n); chk("alm_250c", alarm[3], 1'b0);
        // Inverted thresholds: set takes precedence
        thr_hi[3*IN_W +: IN_W] = 12'd100;
        thr_lo[3*IN_W +: IN_W] = 12'd150;
        load(3, 12'd120); fire(); wait_upd(3, 40, n); chk("alm_setwins", alarm[3], 1'b1);

        // Asynchronous reset in CONV cycle 5
        load(4, 12'd777);
        fire();
        repeat (5) tick();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        reset_reset = 1'b1;
        #1;
        chk("arst_bcd", 64'(bcd_out), 64'd0);
        chk("arst_flags", {ovf, alarm, overrun, bcd_upd}, 20'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        #2;
        reset_reset = 1'b0;
        tick();
        load(1, 12'd11);
        load(3, 12'd33);
        fire();
        wait_upd(1, 40, n);
        chk("post_ch1_lat", n, 14);
        chk("post_ch1_bcd", bcd_of(1), 12'h011);
        wait_upd(3, 40, n);
        chk("post_ch3_gap", n, 14);
        chk("post_ch3_bcd", bcd_of(3), 12'h033);
        repeat (20) tick();
        chk("post_ch4_lost", bcd_of(4), 12'h000);
        chk("post_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
